// File: rtl/piso_framer.sv
`default_nettype none
// ============================================================================
// Module      : piso_framer
// Description : Parallel-in, serial-out framer. Accepts a WIDTH-bit word over
//               a valid/ready handshake and sends it LSB first as
//               START(0), data bits, optional even-parity bit, STOP(1).
// Ports       : clk        - clock, rising-edge active
//               rst        - synchronous active-high reset
//               din        - parallel word, captured on accept
//               din_valid  - upstream word available
//               din_ready  - framer can take a word (IDLE or STOP)
//               sout       - registered serial line, idles high
//               busy       - registered, high from START through STOP
//               frame_done - registered, high during the STOP bit
// Revision    : 1.0 - initial release
// ============================================================================
module piso_framer #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);

    localparam int              c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic [WIDTH-1:0]     r_shreg;
    logic [WIDTH-1:0]     w_shreg_n;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_n;
    logic                 r_par;
    logic                 w_par_n;
    logic                 w_sout_n;
    logic                 w_busy_n;
    logic                 w_done_n;
    logic                 w_accept;

    // Ready in STOP lets a new frame start with no idle gap.
    assign din_ready = (r_state == S_IDLE) || (r_state == S_STOP);
    assign w_accept  = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_par      <= 1'b0;
            sout       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_shreg    <= w_shreg_n;
            r_cnt      <= w_cnt_n;
            r_par      <= w_par_n;
            sout       <= w_sout_n;
            busy       <= w_busy_n;
            frame_done <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_shreg_n = r_shreg;
        w_cnt_n   = r_cnt;
        w_par_n   = r_par;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_n = S_START;
                    w_shreg_n = din;
                    w_par_n   = ^din;
                end
            end
            S_START: begin
                w_state_n = S_DATA;
                w_cnt_n   = '0;
            end
            S_DATA: begin
                w_shreg_n = r_shreg >> 1;
                if (r_cnt == c_last) begin
                    w_state_n = PARITY_EN ? S_PARITY : S_STOP;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                w_state_n = S_STOP;
            end
            S_STOP: begin
                if (w_accept) begin
                    w_state_n = S_START;
                    w_shreg_n = din;
                    w_par_n   = ^din;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state:
        // the value lands on the pins in the same cycle the state does.
        w_sout_n = 1'b1;
        case (w_state_n)
            S_START:  w_sout_n = 1'b0;
            S_DATA:   w_sout_n = w_shreg_n[0];
            S_PARITY: w_sout_n = w_par_n;
            default:  w_sout_n = 1'b1;
        endcase
        w_busy_n = (w_state_n != S_IDLE);
        w_done_n = (w_state_n == S_STOP);
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_framer
// Description : Self-checking bench for piso_framer. One instance with
//               default parameters, one with parity disabled, and a 4-bit
//               right-shift register fed from the default instance's sout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sout;
    logic       busy;
    logic       frame_done;

    logic [3:0] din_np;
    logic       din_valid_np;
    logic       din_ready_np;
    logic       sout_np;
    logic       busy_np;
    logic       frame_done_np;

    logic [3:0] ds;

    always #5 clk = ~clk;

    piso_framer #(.WIDTH(4), .PARITY_EN(1'b1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    piso_framer #(.WIDTH(4), .PARITY_EN(1'b0)) u_np (
        .clk        (clk),
        .rst        (rst),
        .din        (din_np),
        .din_valid  (din_valid_np),
        .din_ready  (din_ready_np),
        .sout       (sout_np),
        .busy       (busy_np),
        .frame_done (frame_done_np)
    );

    // Downstream serial stage: right shift, new bit enters at the MSB.
    always @(posedge clk) ds <= {sout, ds[3:1]};

    typedef struct packed {
        logic sout;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    typedef struct {
        logic [3:0] din;
        logic [6:0] bits;   // bits[i] = sout in frame cycle i
    } vec_t;

    exp_t  q0[$];
    exp_t  q1[$];
    vec_t  tbl[6];
    int    n_chk  = 0;
    int    n_fail = 0;
    string phase  = "init";

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {sout,busy,done,ready/data}=%b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push(input bit np, input logic [6:0] bits, input int n);
        exp_t r;
        for (int i = 0; i < n; i++) begin
            r.sout  = bits[i];
            r.busy  = 1'b1;
            r.done  = (i == n - 1);
            r.ready = (i == n - 1);
            if (np) q1.push_back(r);
            else    q0.push_back(r);
        end
    endtask

    task automatic check_all();
        exp_t e0;
        exp_t e1;
        e0 = 4'b1001;
        e1 = 4'b1001;
        if (q0.size() > 0) e0 = q0.pop_front();
        if (q1.size() > 0) e1 = q1.pop_front();
        cmp({phase, " par"},   {sout, busy, frame_done, din_ready}, e0);
        cmp({phase, " nopar"}, {sout_np, busy_np, frame_done_np, din_ready_np}, e1);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        check_all();
    endtask

    // Pulse valid for one cycle, then scramble din for the rest of the frame.
    task automatic send0(input logic [3:0] d, input logic [6:0] bits);
        din       = d;
        din_valid = 1'b1;
        push(1'b0, bits, 7);
        tick();
        din_valid = 1'b0;
        din       = 4'($urandom);
        repeat (6) tick();
    endtask

    initial begin
        tbl[0] = '{din: 4'b1011, bits: 7'b1110110};
        tbl[1] = '{din: 4'b0000, bits: 7'b1000000};
        tbl[2] = '{din: 4'b1111, bits: 7'b1011110};
        tbl[3] = '{din: 4'b0110, bits: 7'b1001100};
        tbl[4] = '{din: 4'b0001, bits: 7'b1100010};
        tbl[5] = '{din: 4'b1000, bits: 7'b1110000};

        rst          = 1'b1;
        din          = 4'b0000;
        din_valid    = 1'b0;
        din_np       = 4'b0000;
        din_valid_np = 1'b0;

        phase = "reset";
        tick();
        rst   = 1'b0;
        phase = "idle";
        repeat (2) tick();

        phase = "table";
        for (int i = 0; i < 6; i++) begin
            send0(tbl[i].din, tbl[i].bits);
            tick();
            cmp("downstream", ds, tbl[i].bits[6:3]);
        end

        // Back-to-back: valid held high, din swapped mid-frame.
        phase     = "b2b";
        din       = 4'b0000;
        din_valid = 1'b1;
        push(1'b0, tbl[1].bits, 7);
        tick();
        din = 4'b1111;
        repeat (6) tick();
        push(1'b0, tbl[2].bits, 7);
        tick();
        din_valid = 1'b0;
        din       = 4'($urandom);
        repeat (6) tick();
        tick();

        // Reset asserted during the third data bit.
        phase     = "rstmid";
        din       = 4'b0110;
        din_valid = 1'b1;
        push(1'b0, tbl[3].bits, 7);
        tick();
        din_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        q0.delete();
        tick();
        rst = 1'b0;
        tick();
        phase = "postrst";
        send0(tbl[0].din, tbl[0].bits);
        tick();

        // Parity disabled: 1001 -> 0,1,0,0,1,1.
        phase        = "nopar";
        din_np       = 4'b1001;
        din_valid_np = 1'b1;
        push(1'b1, {1'b0, 6'b110010}, 6);
        tick();
        din_valid_np = 1'b0;
        din_np       = 4'($urandom);
        repeat (5) tick();
        tick();

        phase = "idle20";
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_framer.md
# piso_framer

Parallel-in, serial-out framer that takes a WIDTH-bit word over a valid/ready handshake and drives it onto a single serial line, LSB first. Each frame is a start bit, the data bits, an optional even-parity bit and a stop bit. It sits directly upstream of the serial shift-register stages and drives their `d` input from `sout`. It is clocked on the same `clk` and reset by the same `rst`.

## Interface
- `WIDTH`, default 4: data bits per frame; legal range 1 to 32.
- `PARITY_EN`, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- `clk`  input  1: the block's only clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `din`  input  WIDTH: parallel word; sampled only on an accept edge.
- `din_valid`  input  1: upstream has a word on `din`.
- `din_ready`  output  1: framer can accept a word this cycle; combinational from state.
- `sout`  output  1: registered serial line; idles high.
- `busy`  output  1: registered; high from the START bit through the STOP bit.
- `frame_done`  output  1: registered; high for exactly the STOP-bit cycle.

## Operation
- **Accept:** a word is accepted on a rising edge where `din_valid && din_ready` is true.
  - On accept, `din` is captured into an internal shift register and the parity bit (XOR of `din`) is captured.
  - Later changes on `din` are ignored.
- **`din_ready`:** high in state IDLE and in state STOP; low in all other states.
- **States:**
  - IDLE: `sout`=1. On accept, go to START.
  - START: `sout`=0 for 1 cycle, then go to DATA with the bit counter at 0.
  - DATA: `sout` = shift-register bit 0; the register shifts right each cycle.
    - After WIDTH cycles (counter reaches WIDTH-1), go to PARITY if `PARITY_EN` is 1, else to STOP.
  - PARITY: `sout` = captured even-parity bit for 1 cycle, then go to STOP.
  - STOP: `sout`=1 for 1 cycle and `frame_done`=1.
    - If an accept happens in this cycle, go to START (back-to-back frame, no idle gap).
    - Otherwise go to IDLE.
- **Parity:** even parity, so the data bits plus the parity bit contain an even number of ones.
- **Bit counter:** width is $clog2(WIDTH) bits, minimum 1. It never wraps inside a frame and is cleared on entry to DATA.
- **Reset (`rst`=1):** takes effect on the next edge regardless of state, including mid-frame.
  - After that edge: state IDLE, `sout`=1, `busy`=0, `frame_done`=0, shift register and counter cleared.
  - The word in flight is discarded and is not resumed.
  - `din_ready`=1 in the first cycle after reset deasserts.
- **Reset during an accept:** if `rst` and an accept coincide on one edge, reset wins and the word is not captured.
- **Idle hold:** with `din_valid` held low, the framer stays in IDLE indefinitely with `sout`=1.

## Timing
- **Latency:** accept at edge k. The START bit is on `sout` from edge k to edge k+1. Data bit i (LSB is i=0) is on `sout` during cycle k+1+i.
- **Frame length:** WIDTH+2+`PARITY_EN` cycles, i.e. 7 cycles at the defaults.
- **Throughput:**
  - With `din_valid` held high, back-to-back frames are contiguous: one accept every WIDTH+2+`PARITY_EN` cycles.
  - The next START bit immediately follows the STOP bit.
- **`busy`:** rises together with the START bit. It falls after the STOP bit only if no back-to-back accept occurred in STOP.
- **Reset values:** all outputs are registered except `din_ready`. Reset values are `sout`=1, `busy`=0, `frame_done`=0, and `din_ready`=1 once `rst` is low.

## Test plan
- **Single frame, defaults:** `rst` high 1 cycle, then `din`=4'b1011 with `din_valid` pulsed for one cycle.
  - Required `sout` sequence: 0,1,1,0,1,1,1 (start, data LSB first, parity=1, stop).
  - `frame_done` high only in the 7th cycle; `busy` high for cycles 1-7; `sout`=1 afterwards.
- **Back-to-back:** `din_valid` held high with `din`=4'b0000, then 4'b1111.
  - Required `sout`: 0,0,0,0,0,0,1 then immediately 0,1,1,1,1,0,1.
  - `din_ready` high only in IDLE/STOP cycles; `busy` never drops between the frames.
- **Reset mid-frame:** start a frame with 4'b0110 and assert `rst` during the 3rd data bit.
  - Next cycle: `sout`=1, `busy`=0, `frame_done`=0, and no further frame bits.
  - A new accept after reset produces a clean 7-bit frame.
- **No parity:** `PARITY_EN`=0, `din`=4'b1001.
  - Required `sout`: 0,1,0,0,1,1 (6 cycles); `frame_done` in the 6th cycle.
- **Idle and input stability:**
  - With `din_valid`=0 for 20 cycles, `sout` stays 1 and `din_ready` stays 1.
  - Changing `din` mid-frame does not alter the serial bits.
- **Downstream hookup:** connect `sout` to a 4-bit right-shift register's `d`.
  - After the frame for 4'b1011, the shift register contents must match the last four serial bits in shift order.
